// File: rtl/regfile_write_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_queue_if
// Description : Push, bank-write and forwarding signals of the write queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_write_queue_if #(
    parameter int WIDTH     = 8,
    parameter int ADD_WIDTH = 5,
    parameter int DEPTH     = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [ADD_WIDTH-1:0]     in_reg;
    logic [WIDTH-1:0]         in_data;
    logic                     wb_stall;
    logic                     w_en;
    logic [ADD_WIDTH-1:0]     w_reg;
    logic [WIDTH-1:0]         w_data;
    logic [ADD_WIDTH-1:0]     fwd_reg1;
    logic [ADD_WIDTH-1:0]     fwd_reg2;
    logic                     fwd_hit1;
    logic                     fwd_hit2;
    logic [WIDTH-1:0]         fwd_data1;
    logic [WIDTH-1:0]         fwd_data2;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_reg, in_data, wb_stall, fwd_reg1, fwd_reg2,
        input  in_ready, w_en, w_reg, w_data, fwd_hit1, fwd_hit2,
               fwd_data1, fwd_data2, count
    );

    modport slave (
        input  in_valid, in_reg, in_data, wb_stall, fwd_reg1, fwd_reg2,
        output in_ready, w_en, w_reg, w_data, fwd_hit1, fwd_hit2,
               fwd_data1, fwd_data2, count
    );
endinterface
`default_nettype wire

// File: rtl/regfile_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_queue
// Description : In-order write-back queue in front of the register bank's
//               single write port, with two youngest-match forwarding lookups.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_queue #(
    parameter int WIDTH     = 8,
    parameter int ADD_WIDTH = 5,
    parameter int DEPTH     = 4
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    regfile_write_queue_if.slave     bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [ADD_WIDTH-1:0] r_reg_mem  [DEPTH];
    logic [WIDTH-1:0]     r_data_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [c_PTR_W-1:0]   w_age_idx   [DEPTH];
    logic                 w_age_valid [DEPTH];

    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    // Register 0 completes the handshake but is never stored: the bank ignores it.
    assign w_push  = bus.in_valid && !w_full && (bus.in_reg != '0);
    assign w_pop   = !w_empty && !bus.wb_stall;

    assign bus.in_ready = !w_full;
    assign bus.w_en     = w_pop;
    assign bus.w_reg    = r_reg_mem[r_rd_ptr];
    assign bus.w_data   = r_data_mem[r_rd_ptr];
    assign bus.count    = r_count;

    // Slot index ordered by age: age 0 is the head, larger ages are younger.
    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_age
            assign w_age_idx[g]   = r_rd_ptr + c_PTR_W'(g);
            assign w_age_valid[g] = (c_CNT_W'(g) < r_count);
        end
    endgenerate

    // Scan oldest to youngest so the last match, the youngest, wins.
    always_comb begin
        bus.fwd_hit1  = 1'b0;
        bus.fwd_data1 = '0;
        bus.fwd_hit2  = 1'b0;
        bus.fwd_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_age_valid[i] && (bus.fwd_reg1 != '0) &&
                (r_reg_mem[w_age_idx[i]] == bus.fwd_reg1)) begin
                bus.fwd_hit1  = 1'b1;
                bus.fwd_data1 = r_data_mem[w_age_idx[i]];
            end
            if (w_age_valid[i] && (bus.fwd_reg2 != '0) &&
                (r_reg_mem[w_age_idx[i]] == bus.fwd_reg2)) begin
                bus.fwd_hit2  = 1'b1;
                bus.fwd_data2 = r_data_mem[w_age_idx[i]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // Payload storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_reg_mem[r_wr_ptr]  <= bus.in_reg;
            r_data_mem[r_wr_ptr] <= bus.in_data;
        end
    end
endmodule
`default_nettype wire

// File: doc/regfile_write_queue.md
# regfile_write_queue

Buffered write-back path in front of the register bank's single write port. Accepts register writes from the pipeline's write-back stage through a valid/ready handshake and holds them in a small in-order queue. Retires them one per cycle onto the bank's `w_en`/`w_reg`/`w_data` inputs whenever the port is not stalled. Provides two forwarding lookups so readers of the bank see pending (not yet written) values.

## Interface
- `WIDTH`, 8, register data width; matches the bank.
- `ADD_WIDTH`, 5, register address width; matches the bank.
- `DEPTH`, 4, queue entries; power of two, at least 2.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `in_valid`  input  1  write request present.
- `in_ready`  output  1  queue can accept; equals !full.
- `in_reg`  input  ADD_WIDTH  destination register.
- `in_data`  input  WIDTH  write data.
- `wb_stall`  input  1  bank write port unavailable this cycle.
- `w_en`  output  1  to bank: head entry valid and not stalled.
- `w_reg`  output  ADD_WIDTH  to bank: head entry register.
- `w_data`  output  WIDTH  to bank: head entry data.
- `fwd_reg1`, `fwd_reg2`  input  ADD_WIDTH  reader lookup addresses; same values as the bank's `r_reg1`/`r_reg2`.
- `fwd_hit1`, `fwd_hit2`  output  1  a pending entry targets that register.
- `fwd_data1`, `fwd_data2`  output  WIDTH  data of the youngest matching entry; 0 when no hit.
- `count`  output  clog2(DEPTH)+1  number of valid entries.

## Operation
- Storage: circular buffer of DEPTH entries (reg, data) with read pointer, write pointer, and an occupancy counter.
  - Pointers wrap modulo DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
- Push: `in_valid && in_ready` writes (`in_reg`, `in_data`) at the write pointer.
  - Exception: `in_reg == 0` is accepted (handshake completes) but not enqueued. Register 0 is hard-wired zero in the bank.
- Pop: `w_en = !empty && !wb_stall`. When `w_en` is high, the read pointer advances at the clock edge.
- `w_reg`/`w_data` always present the head entry; they are don't-care when empty. `w_en` is combinational from state and `wb_stall`.
- Simultaneous push and pop: count is unchanged; both pointers advance.
  - Not possible when full, because `in_ready` = 0.
  - When empty, the pushed entry is not popped in the same cycle; it becomes the head next cycle.
- Ordering: strict FIFO. Two queued writes to the same register retire oldest first, so the bank ends with the youngest value.
- Forwarding (combinational):
  - `fwd_hitN` = 1 when some valid entry (including the head being written this cycle) has reg == `fwd_regN`, and `fwd_regN != 0`.
  - `fwd_dataN` = data of the youngest such entry.
  - Same-cycle `in_data` is not forwarded.
  - Readers select `fwd_dataN` over the bank's `read_dataN` on hit.
- `in_ready` depends only on registered state; there is no path from `wb_stall` or `in_valid`.

## Timing
- Reset (async assert, sync release): pointers 0, count 0, all entries invalid.
  - Outputs during reset: `w_en` 0, `in_ready` 1, `fwd_hit*` 0, `fwd_data*` 0.
- Reset mid-operation discards all pending entries; no write reaches the bank.
- Latency: a write accepted at edge N is head at cycle N+1. With no stall, `w_en` is high in cycle N+1 and the bank is updated at edge N+2.
- Throughput: one push and one pop per cycle sustained.
- Forwarding is valid from cycle N+1 until the cycle the entry's bank write occurs, inclusive. From the following cycle the bank read path returns the value.
- With `wb_stall` held high, the queue fills after DEPTH accepted pushes. `in_ready` falls the cycle after the DEPTH-th push.

## Test plan
- Reset then single write: push reg 3 = 0xA5.
  - Next cycle: `w_en` 1, `w_reg` 3, `w_data` 0xA5, `fwd_hit1` 1 for `fwd_reg1` = 3.
  - Cycle after: `w_en` 0, count 0, hit 0.
- Fill under stall (`wb_stall` = 1), DEPTH = 4: push reg 1..4 = 0x11..0x44.
  - `in_ready` 0 and count 4; a 5th `in_valid` is not accepted.
  - Release stall: bank writes regs 1,2,3,4 in order on consecutive cycles.
- Same-register ordering: push reg 5 = 0x01 then reg 5 = 0x02 under stall.
  - `fwd_data1` for reg 5 is 0x02.
  - After drain, reading reg 5 from the bank returns 0x02.
- Register 0: push reg 0 = 0xFF.
  - `in_ready` stays 1, count stays 0, `w_en` never asserts.
  - `fwd_hit` with `fwd_reg` = 0 is always 0.
- Wrap-around with simultaneous push/pop: stream 10 writes back to back with no stall.
  - count holds at 1; all 10 reach the bank in order with correct data.
- Async reset with 3 entries queued: drop `rst_n` mid-cycle.
  - Immediately: `w_en` 0, count 0, `in_ready` 1.
  - No further bank writes occur after release.
